truth_table_sweeper: RTL and testbench

- Sequenced stimulus-and-capture stage wrapped around a combinational SoP/PoS truth-table block.
- On each start it drives every input vector into the downstream block: {x,y,z} for 8 vectors, or {x,y,w,z} for 16 vectors.
- It samples the block's outputs after a programmable settle time and assembles one truth-table word per output.
- It then compares the words against expected values and raises per-output mismatch flags, replacing hand-read $monitor dumps with a self-checking hardware sequencer.

---
 rtl/truth_table_sweeper_if.sv | 28 ++
 rtl/truth_table_sweeper.sv | 149 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
// Bundle between the truth-table sweeper and whoever owns start/exp and reads results.
// The sweeper holds the slave modport; the block under sweep feeds s back through it.
interface truth_table_sweeper_if #(
  parameter int N_OUT = 5
);
  logic                  start;
  logic                  four_var;
  logic [N_OUT-1:0]      s;
  logic [N_OUT*16-1:0]   exp;
  logic                  x;
  logic                  y;
  logic                  w;
  logic                  z;
  logic                  busy;
  logic                  done;
  logic [N_OUT*16-1:0]   tt;
  logic [N_OUT-1:0]      mismatch;

  modport master (
    output start, four_var, s, exp,
    input  x, y, w, z, busy, done, tt, mismatch
  );

  modport slave (
    input  start, four_var, s, exp,
    output x, y, w, z, busy, done, tt, mismatch
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Drives every input vector into a combinational block, captures one truth-table
// word per output after SETTLE idle cycles, then flags outputs that differ from exp.
module truth_table_sweeper #(
  parameter int N_OUT  = 5,
  parameter int SETTLE = 1
) (
  input logic               clk,
  input logic               rst_n,
  truth_table_sweeper_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  localparam state_t     AFTER_VEC   = (SETTLE > 0) ? DRIVE : SAMPLE;

  state_t              state_reg, state_next;
  logic [3:0]          idx_reg, idx_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                mode_reg, mode_next;
  logic [3:0]          stim_reg, stim_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic [N_OUT*16-1:0] tt_reg, tt_next;
  logic [N_OUT-1:0]    mism_reg, mism_next;

  logic [N_OUT*16-1:0] tt_cap;
  logic [N_OUT-1:0]    mism_now;
  logic [15:0]         word_mask;
  logic [3:0]          last_idx;

  // Stimulus is packed {x,y,w,z}; in 3-variable mode w is held low.
  function automatic logic [3:0] stim_of(input logic [3:0] i, input logic four);
    return four ? i : {i[2], i[1], 1'b0, i[0]};
  endfunction

  assign word_mask = mode_reg ? 16'hFFFF : 16'h00FF;
  assign last_idx  = mode_reg ? 4'd15 : 4'd7;

  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
      logic [15:0] cap_word;

      always_comb begin
        cap_word          = tt_reg[gi*16 +: 16];
        cap_word[idx_reg] = bus.s[gi];
      end

      assign tt_cap[gi*16 +: 16] = cap_word;
      assign mism_now[gi] = |((tt_reg[gi*16 +: 16] ^ bus.exp[gi*16 +: 16]) & word_mask);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      mode_reg  <= 1'b0;
      stim_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      tt_reg    <= '0;
      mism_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
      stim_reg  <= stim_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      tt_reg    <= tt_next;
      mism_reg  <= mism_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    stim_next  = stim_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    tt_next    = tt_reg;
    mism_next  = mism_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          mode_next  = bus.four_var;
          tt_next    = '0;
          mism_next  = '0;
          idx_next   = '0;
          cnt_next   = '0;
          busy_next  = 1'b1;
          stim_next  = stim_of(4'd0, bus.four_var);
          state_next = AFTER_VEC;
        end
      end

      DRIVE: begin
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == SETTLE_LAST) begin
          state_next = SAMPLE;
        end
      end

      SAMPLE: begin
        tt_next = tt_cap;
        if (idx_reg == last_idx) begin
          busy_next  = 1'b0;
          done_next  = 1'b1;
          stim_next  = '0;
          state_next = DONE;
        end else begin
          idx_next   = idx_reg + 4'd1;
          cnt_next   = '0;
          stim_next  = stim_of(idx_reg + 4'd1, mode_reg);
          state_next = AFTER_VEC;
        end
      end

      DONE: begin
        // exp is only looked at here; the verdict is frozen for the following IDLE.
        mism_next  = mism_now;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.x        = stim_reg[3];
  assign bus.y        = stim_reg[2];
  assign bus.w        = stim_reg[1];
  assign bus.z        = stim_reg[0];
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.tt       = tt_reg;
  assign bus.mismatch = done_reg ? mism_now : mism_reg;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Three sweepers (SETTLE = 1, 0, 3) around table-driven blocks, checked every cycle
// against a sweep-level model plus directed literal expectations.
module tb_truth_table_sweeper;

  localparam int N = 5;
  localparam int ST [3] = '{1, 0, 3};
  // Block functions per instance; instance 0 holds 3-variable tables indexed by {x,y,z}.
  localparam logic [15:0] FN [3][5] = '{
    '{16'h00E4, 16'h00CA, 16'h005A, 16'h000F, 16'h0081},
    '{16'h1234, 16'hFFFF, 16'h90D6, 16'h3526, 16'h22A5},
    '{16'h8001, 16'h0000, 16'h90D6, 16'h3526, 16'h22A5}
  };

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic          start_v [3];
  logic          four_v  [3];
  logic [79:0]   exp_v   [3];
  logic [3:0]    stim_o  [3];
  logic          busy_o  [3];
  logic          done_o  [3];
  logic [79:0]   tt_o    [3];
  logic [4:0]    mm_o    [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  function automatic logic [4:0] blk(input int i, input logic [3:0] v);
    logic [4:0]  r;
    logic [15:0] t;
    logic [2:0]  m3;
    m3 = {v[3], v[2], v[0]};
    for (int o = 0; o < N; o++) begin
      t = FN[i][o];
      r[o] = (i == 0) ? t[m3] : t[v];
    end
    if (i == 0) begin
      // s1 = ~x&y&~z | x&~y&z | x&y&~z | x&y&z
      r[0] = (~v[3] & v[2] & ~v[0]) | (v[3] & ~v[2] & v[0]) |
             (v[3] & v[2] & ~v[0]) | (v[3] & v[2] & v[0]);
    end
    return r;
  endfunction

  truth_table_sweeper_if #(.N_OUT(N)) bus [3] ();

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      truth_table_sweeper #(.N_OUT(N), .SETTLE(ST[gi])) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus[gi])
      );
      assign bus[gi].start    = start_v[gi];
      assign bus[gi].four_var = four_v[gi];
      assign bus[gi].exp      = exp_v[gi];
      assign bus[gi].s        = blk(gi, {bus[gi].x, bus[gi].y, bus[gi].w, bus[gi].z});
      assign stim_o[gi] = {bus[gi].x, bus[gi].y, bus[gi].w, bus[gi].z};
      assign busy_o[gi] = bus[gi].busy;
      assign done_o[gi] = bus[gi].done;
      assign tt_o[gi]   = bus[gi].tt;
      assign mm_o[gi]   = bus[gi].mismatch;
    end
  endgenerate

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  // ---------------- sweep-level model ----------------
  function automatic logic [3:0] vec_of(input int k, input logic four);
    logic [3:0] kk;
    kk = 4'(k);
    return four ? kk : {kk[2], kk[1], 1'b0, kk[0]};
  endfunction

  function automatic logic [79:0] model_tt(input int i, input logic four, input int n);
    logic [79:0] r;
    logic [4:0]  b;
    r = '0;
    for (int m = 0; m < n; m++) begin
      b = blk(i, vec_of(m, four));
      for (int o = 0; o < N; o++) r[o*16 + m] = b[o];
    end
    return r;
  endfunction

  function automatic logic [4:0] model_mm(input int i, input logic four, input logic [79:0] e);
    logic [79:0] t;
    logic [15:0] mask;
    logic [4:0]  r;
    t    = model_tt(i, four, four ? 16 : 8);
    mask = four ? 16'hFFFF : 16'h00FF;
    for (int o = 0; o < N; o++) r[o] = (t[o*16 +: 16] != (e[o*16 +: 16] & mask));
    return r;
  endfunction

  int          ph      [3];  // 0 idle, 1 sweeping, 2 done cycle
  int          cyc     [3];
  logic        mode_m  [3];
  logic [79:0] tt_hold [3];
  logic [4:0]  mm_hold [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      ph[i] = 0; cyc[i] = 0; mode_m[i] = 1'b0; tt_hold[i] = '0; mm_hold[i] = '0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        ph[i] <= 0; cyc[i] <= 0; mode_m[i] <= 1'b0; tt_hold[i] <= '0; mm_hold[i] <= '0;
      end else if (ph[i] == 0) begin
        if (start_v[i]) begin
          ph[i] <= 1; cyc[i] <= 0; mode_m[i] <= four_v[i];
          tt_hold[i] <= '0; mm_hold[i] <= '0;
        end
      end else if (ph[i] == 1) begin
        cyc[i] <= cyc[i] + 1;
        if (cyc[i] + 1 == (mode_m[i] ? 16 : 8) * (ST[i] + 1)) ph[i] <= 2;
      end else begin
        tt_hold[i] <= model_tt(i, mode_m[i], mode_m[i] ? 16 : 8);
        mm_hold[i] <= model_mm(i, mode_m[i], exp_v[i]);
        ph[i] <= 0;
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [3:0]  e_stim;
    logic        e_busy, e_done;
    logic [79:0] e_tt;
    logic [4:0]  e_mm;
    for (int i = 0; i < 3; i++) begin
      e_stim = '0; e_busy = 1'b0; e_done = 1'b0; e_tt = tt_hold[i]; e_mm = mm_hold[i];
      if (ph[i] == 1) begin
        e_stim = vec_of(cyc[i] / (ST[i] + 1), mode_m[i]);
        e_busy = 1'b1;
        e_tt   = model_tt(i, mode_m[i], cyc[i] / (ST[i] + 1));
        e_mm   = '0;
      end else if (ph[i] == 2) begin
        e_done = 1'b1;
        e_tt   = model_tt(i, mode_m[i], mode_m[i] ? 16 : 8);
        e_mm   = model_mm(i, mode_m[i], exp_v[i]);
      end
      chk($sformatf("u%0d_stim", i), 80'(stim_o[i]), 80'(e_stim));
      chk($sformatf("u%0d_busy_done", i), 80'({busy_o[i], done_o[i]}), 80'({e_busy, e_done}));
      chk($sformatf("u%0d_tt", i), tt_o[i], e_tt);
      chk($sformatf("u%0d_mismatch", i), 80'(mm_o[i]), 80'(e_mm));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic sweep(input int i, input logic four, input logic hold, input int poke,
                       output int lat, output int bcnt);
    @(posedge clk); #1;
    start_v[i] = 1'b1;
    four_v[i]  = four;
    @(posedge clk); #1;
    if (!hold) start_v[i] = 1'b0;
    lat  = 0;
    bcnt = busy_o[i] ? 1 : 0;
    while (!done_o[i] && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (busy_o[i]) bcnt++;
      if (lat == poke) begin
        start_v[i] = 1'b1;
        four_v[i]  = ~four;
      end else if (lat == poke + 1 && !hold) begin
        start_v[i] = 1'b0;
      end
    end
    if (!done_o[i]) chk($sformatf("u%0d_done_timeout", i), 80'(done_o[i]), 80'd1);
  endtask

  initial begin
    int lat, bcnt, seen, gap;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      four_v[i]  = 1'b0;
    end
    // Upper byte of word 0 is junk: it must not matter in 3-variable mode.
    exp_v[0] = {16'h0081, 16'h000F, 16'h005A, 16'h00CA, 16'hAAE4};
    exp_v[1] = {16'h22A5, 16'h3526, 16'h90D6, 16'hFFFF, 16'h1234};
    exp_v[2] = {16'h22A4, 16'h3526, 16'h90D6, 16'h0000, 16'h8001};

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_tt", tt_o[0], 80'd0);
    chk("reset_busy_done", 80'({busy_o[0], done_o[0]}), 80'd0);

    // 3-variable, SETTLE=1
    sweep(0, 1'b0, 1'b0, -1, lat, bcnt);
    chk("u0_latency", 80'(lat), 80'd16);
    chk("u0_s1_word", 80'(tt_o[0][15:0]), 80'h00E4);
    chk("u0_s2_word", 80'(tt_o[0][31:16]), 80'h00CA);
    chk("u0_upper_zero", 80'(tt_o[0][15:8]), 80'h0);
    chk("u0_mismatch_clean", 80'(mm_o[0]), 80'h00);

    exp_v[0][31:16] = 16'h00CB;
    sweep(0, 1'b0, 1'b0, -1, lat, bcnt);
    chk("u0_inject_mismatch", 80'(mm_o[0]), 80'h02);

    // 4-variable, SETTLE=0
    sweep(1, 1'b1, 1'b0, -1, lat, bcnt);
    chk("u1_latency", 80'(lat), 80'd16);
    chk("u1_busy_cycles", 80'(bcnt), 80'd16);
    chk("u1_s3_word", 80'(tt_o[1][47:32]), 80'h90D6);
    chk("u1_s4_word", 80'(tt_o[1][63:48]), 80'h3526);
    chk("u1_s5_word", 80'(tt_o[1][79:64]), 80'h22A5);
    chk("u1_mismatch", 80'(mm_o[1]), 80'h00);

    // 4-variable, SETTLE=3, with a stray start and mode flip mid-sweep
    sweep(2, 1'b1, 1'b0, 20, lat, bcnt);
    chk("u2_latency", 80'(lat), 80'd64);
    chk("u2_mismatch", 80'(mm_o[2]), 80'h10);
    @(posedge clk); #1;
    chk("u2_single_done", 80'(done_o[2]), 80'd0);
    chk("u2_stim_zero", 80'(stim_o[2]), 80'd0);
    chk("u2_mismatch_hold", 80'(mm_o[2]), 80'h10);

    // Asynchronous reset while instance 0 drives idx 5
    exp_v[0][31:16] = 16'h00CA;
    @(posedge clk); #1;
    start_v[0] = 1'b1;
    four_v[0]  = 1'b0;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("u0_pre_reset_idx5", 80'(stim_o[0]), 80'(4'b1001));
    #1 rst_n = 1'b0;
    #1;
    chk("abort_stim", 80'(stim_o[0]), 80'd0);
    chk("abort_busy_done", 80'({busy_o[0], done_o[0]}), 80'd0);
    chk("abort_tt", tt_o[0], 80'd0);
    chk("abort_mismatch", 80'(mm_o[0]), 80'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o[0] || busy_o[0]) seen++;
    end
    chk("no_done_after_abort", 80'(seen), 80'd0);
    sweep(0, 1'b0, 1'b0, -1, lat, bcnt);
    chk("u0_resweep_latency", 80'(lat), 80'd16);
    chk("u0_resweep_s1", 80'(tt_o[0][15:0]), 80'h00E4);
    chk("u0_resweep_mismatch", 80'(mm_o[0]), 80'h00);

    // start held high through DONE re-triggers after one idle cycle
    sweep(1, 1'b1, 1'b1, -1, lat, bcnt);
    chk("u1_held_latency", 80'(lat), 80'd16);
    gap = 0;
    while (!busy_o[1] && gap < 10) begin
      @(posedge clk); #1;
      gap++;
    end
    chk("u1_retrigger_gap", 80'(gap), 80'd2);
    chk("u1_tt_cleared", tt_o[1], 80'd0);
    start_v[1] = 1'b0;
    lat = 0;
    while (!done_o[1] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("u1_second_latency", 80'(lat), 80'd16);
    chk("u1_second_s5", 80'(tt_o[1][79:64]), 80'h22A5);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
